// File: rtl/alu_defs.sv
// Shared ALU definitions: op-codes, operand/op widths and the issue-buffer occupancy encoding.
package alu_defs;

    localparam int WIDTH    = 32;
    localparam int OPW      = 3;
    localparam int BUNDLE_W = 2 * WIDTH + OPW;

    localparam logic [OPW-1:0] ALU_AND = 3'd0;
    localparam logic [OPW-1:0] ALU_OR  = 3'd1;
    localparam logic [OPW-1:0] ALU_ADD = 3'd2;
    localparam logic [OPW-1:0] ALU_XOR = 3'd3;
    localparam logic [OPW-1:0] ALU_NOR = 3'd4;
    localparam logic [OPW-1:0] ALU_SRL = 3'd5;
    localparam logic [OPW-1:0] ALU_SUB = 3'd6;
    localparam logic [OPW-1:0] ALU_SLT = 3'd7;

    // The state value doubles as the occupancy count presented on the port.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/issue_slot.sv
// One buffered {A, B, op} bundle plus its valid bit; clear drops only the valid bit.
module issue_slot #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OPW-1:0]   op_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [OPW-1:0]   op_o
);

    logic             valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            a_q     <= a_i;
            b_q     <= b_i;
            op_q    <= op_i;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign op_o    = op_q;

endmodule

// File: rtl/alu_issue_buf.sv
// Two-entry skid buffer in front of the ALU; in_ready is registered so the
// execute-stage ready never reaches decode combinationally.
module alu_issue_buf #(
    parameter int WIDTH = alu_defs::WIDTH,
    parameter int OPW   = alu_defs::OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [OPW-1:0]   out_op,
    output logic [1:0]       occupancy
);

    import alu_defs::*;

    occ_e st_q, st_d;
    logic in_ready_q;

    logic accept, consume;
    logic main_load, main_clr, main_from_skid;
    logic skid_load, skid_clr;

    logic             main_valid, skid_valid;
    logic [WIDTH-1:0] skid_a, skid_b;
    logic [OPW-1:0]   skid_op;
    logic [WIDTH-1:0] main_a_d, main_b_d;
    logic [OPW-1:0]   main_op_d;

    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid && out_ready;

    always_comb begin
        st_d           = st_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        case (st_q)
            OCC_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    st_d      = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && consume) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    st_d      = OCC_TWO;
                end else if (consume) begin
                    main_clr = 1'b1;
                    st_d     = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (consume) begin
                    main_load      = 1'b1;
                    main_from_skid = skid_valid;
                    skid_clr       = 1'b1;
                    st_d           = OCC_ONE;
                end
            end
            default: st_d = OCC_EMPTY;
        endcase
        // Flush wins over any transfer; data registers keep their contents.
        if (flush) begin
            st_d      = OCC_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            st_q       <= st_d;
            in_ready_q <= (st_d != OCC_TWO);
        end
    end

    assign main_a_d  = main_from_skid ? skid_a  : in_a;
    assign main_b_d  = main_from_skid ? skid_b  : in_b;
    assign main_op_d = main_from_skid ? skid_op : in_op;

    issue_slot #(.WIDTH(WIDTH), .OPW(OPW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clr_i   (main_clr),
        .a_i     (main_a_d),
        .b_i     (main_b_d),
        .op_i    (main_op_d),
        .valid_o (main_valid),
        .a_o     (out_a),
        .b_o     (out_b),
        .op_o    (out_op)
    );

    issue_slot #(.WIDTH(WIDTH), .OPW(OPW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clr_i   (skid_clr),
        .a_i     (in_a),
        .b_i     (in_b),
        .op_i    (in_op),
        .valid_o (skid_valid),
        .a_o     (skid_a),
        .b_o     (skid_b),
        .op_o    (skid_op)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign occupancy = st_q;

endmodule

// File: tb/tb_alu_issue_buf.sv
// Randomized and directed checks of alu_issue_buf against a FIFO-queue reference model.
module tb_alu_issue_buf;

    import alu_defs::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    bundle_t mq[$];

    always #5 clk = ~clk;

    alu_issue_buf #(.WIDTH(32), .OPW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = mq.size();
        check("occupancy", 32'(occupancy), 32'(n));
        check("out_valid", 32'(out_valid), 32'(n > 0));
        check("in_ready", 32'(in_ready), 32'(n < 2));
        if (n > 0) begin
            check("out_a", out_a, mq[0].a);
            check("out_b", out_b, mq[0].b);
            check("out_op", 32'(out_op), 32'(mq[0].op));
        end
    endtask

    // Called at a negedge: drive inputs, step the model at posedge, check at next negedge.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic ordy);
        bit acc, cons;
        bundle_t nb;
        rst = r; flush = f; in_valid = iv; in_a = a; in_b = b; in_op = op; out_ready = ordy;
        @(posedge clk);
        acc  = iv && (mq.size() < 2);
        cons = (mq.size() > 0) && ordy;
        if (r || f) begin
            mq.delete();
        end else begin
            if (cons) void'(mq.pop_front());
            if (acc) begin
                nb.a = a; nb.b = b; nb.op = op;
                mq.push_back(nb);
            end
        end
        @(negedge clk);
        $display("cyc rst=%0b flush=%0b iv=%0b a=%h ordy=%0b -> occ=%0d ov=%0b ir=%0b out_a=%h",
                 r, f, iv, a, ordy, occupancy, out_valid, in_ready, out_a);
        check_outputs();
    endtask

    initial begin
        @(negedge clk);

        // Reset then idle
        cyc(1, 0, 0, 32'h0, 32'h0, 3'd0, 0);
        cyc(1, 0, 0, 32'h0, 32'h0, 3'd0, 0);
        check("rst_out_a", out_a, 32'h0);
        check("rst_out_b", out_b, 32'h0);
        check("rst_out_op", 32'(out_op), 32'h0);
        cyc(0, 0, 0, 32'h0, 32'h0, 3'd0, 0);
        check("idle_in_ready", 32'(in_ready), 32'h1);

        // Streaming XOR bundles
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 32'hFFFF0000, 32'h0F0F0F0F, ALU_XOR, 1);
            check("stream_occ", 32'(occupancy), 32'd1);
            check("stream_xor", out_a ^ out_b, 32'hF0F00F0F);
        end
        cyc(0, 0, 0, 32'h0, 32'h0, 3'd0, 1);

        // Backpressure
        cyc(0, 0, 1, 32'd1, 32'h11, ALU_ADD, 0);
        cyc(0, 0, 1, 32'd2, 32'h22, ALU_SUB, 0);
        check("bp_occ", 32'(occupancy), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_a", out_a, 32'd1);
        cyc(0, 0, 0, 32'h0, 32'h0, 3'd0, 0);
        check("bp_hold_a", out_a, 32'd1);
        cyc(0, 0, 0, 32'h0, 32'h0, 3'd0, 1);
        check("bp_second_a", out_a, 32'd2);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        cyc(0, 0, 0, 32'h0, 32'h0, 3'd0, 1);

        // Flush while full with a simultaneous input
        cyc(0, 0, 1, 32'hA1, 32'hB1, ALU_OR, 0);
        cyc(0, 0, 1, 32'hA2, 32'hB2, ALU_NOR, 0);
        cyc(0, 1, 1, 32'hA3, 32'hB3, ALU_SRL, 0);
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_ov", 32'(out_valid), 32'd0);
        check("flush_ir", 32'(in_ready), 32'd1);

        // Simultaneous accept and consume at occupancy one
        cyc(0, 0, 1, 32'hCAFEF00D, 32'h5, ALU_AND, 0);
        cyc(0, 0, 1, 32'h12345678, 32'h9, ALU_SLT, 1);
        check("simul_occ", 32'(occupancy), 32'd1);
        check("simul_a", out_a, 32'h12345678);

        // Reset while full and stalled
        cyc(0, 0, 1, 32'hD1, 32'hE1, ALU_ADD, 0);
        check("prerst_occ", 32'(occupancy), 32'd2);
        cyc(1, 0, 0, 32'h0, 32'h0, 3'd0, 0);
        check("rstfull_ov", 32'(out_valid), 32'd0);
        cyc(0, 0, 0, 32'h0, 32'h0, 3'd0, 1);
        check("postrst_ov", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), $urandom, $urandom, 3'($urandom),
                ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
